// File: rtl/axis_incr_pattern_checker.sv
// axis_incr_pattern_checker
// AXI-Stream sink that applies a programmable TREADY back-pressure pattern and
// checks a byte-wise auto-increment data pattern. Keeps beat/packet/error
// counters and records the beat index of the first mismatching beat.

module axis_incr_pattern_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter bit RESYNC_ON_LAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [1:0]            cfg_ready_mode,
  input  logic [7:0]            cfg_high_time,
  input  logic [7:0]            cfg_low_time,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_last,
  output logic [31:0]           beat_count,
  output logic [31:0]           packet_count,
  output logic [15:0]           error_count,
  output logic [31:0]           first_err_beat,
  output logic                  error,
  output logic                  locked
);

  localparam int         BYTES     = DATA_WIDTH / 8;
  localparam logic [7:0] BYTES_INC = 8'(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state;
  logic [7:0] exp_byte;

  // ---------------------------------------------------------------------------
  // Ready pattern generator
  // ---------------------------------------------------------------------------
  logic [1:0] mode_last;
  logic [7:0] high_last;
  logic [7:0] low_last;
  logic [8:0] phase;
  logic       cfg_write;
  logic [8:0] period;
  logic [8:0] phase_cur;
  logic [8:0] phase_inc;
  logic [8:0] phase_wrap;
  logic       ready_next;

  // Any change of a configuration field counts as a write and restarts the
  // period at the first cycle of its high phase.
  assign cfg_write  = (cfg_ready_mode != mode_last) ||
                      (cfg_high_time  != high_last) ||
                      (cfg_low_time   != low_last);
  assign period     = {1'b0, cfg_high_time} + {1'b0, cfg_low_time};
  assign phase_cur  = cfg_write ? 9'd0 : phase;
  assign phase_inc  = phase_cur + 9'd1;
  assign phase_wrap = (phase_inc >= period) ? 9'd0 : phase_inc;

  // Ready level for the next cycle; only the pattern mode looks at the phase.
  always_comb begin
    ready_next = 1'b0;
    case (cfg_ready_mode)
      2'd0:    ready_next = 1'b1;
      2'd1:    ready_next = (phase_cur < {1'b0, cfg_high_time});
      default: ready_next = 1'b0;
    endcase
    if (!enable) ready_next = 1'b0;
  end

  // Registered ready plus the free-running phase counter (frozen while disabled).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_last    <= 2'd0;
      high_last    <= 8'd0;
      low_last     <= 8'd0;
      phase        <= 9'd0;
      s_axis_ready <= 1'b0;
    end else begin
      mode_last    <= cfg_ready_mode;
      high_last    <= cfg_high_time;
      low_last     <= cfg_low_time;
      s_axis_ready <= ready_next;
      if (enable)         phase <= phase_wrap;
      else if (cfg_write) phase <= 9'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern comparison
  // ---------------------------------------------------------------------------
  logic [BYTES-1:0] lane_bad;
  logic             mismatch;
  logic             accept;
  logic [7:0]       seed;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign lane_bad[gi] = (s_axis_data[8*gi +: 8] != 8'(exp_byte + 8'(gi)));
  end

  assign mismatch = |lane_bad;
  assign accept   = s_axis_valid & s_axis_ready;
  assign seed     = s_axis_data[7:0] + BYTES_INC;
  assign locked   = (state == CHECK);

  // Checker FSM, counters and error capture; clear wins over a same-cycle beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      exp_byte       <= 8'd0;
      beat_count     <= 32'd0;
      packet_count   <= 32'd0;
      error_count    <= 16'd0;
      first_err_beat <= 32'd0;
      error          <= 1'b0;
    end else if (clear) begin
      beat_count     <= 32'd0;
      packet_count   <= 32'd0;
      error_count    <= 16'd0;
      first_err_beat <= 32'd0;
      error          <= 1'b0;
      state          <= enable ? SEEK : IDLE;
    end else begin
      if (accept) begin
        if (beat_count != 32'hFFFF_FFFF) beat_count <= beat_count + 32'd1;
        if (s_axis_last && (packet_count != 32'hFFFF_FFFF))
          packet_count <= packet_count + 32'd1;

        if (state == SEEK) begin
          exp_byte <= seed;
        end else if (state == CHECK) begin
          if (mismatch) begin
            // Re-seed from the received beat so one bad beat costs one error.
            exp_byte <= seed;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (!error) begin
              error          <= 1'b1;
              first_err_beat <= beat_count;
            end
          end else begin
            exp_byte <= exp_byte + BYTES_INC;
          end
        end
      end

      case (state)
        IDLE: begin
          if (enable) state <= SEEK;
        end
        SEEK: begin
          if (!enable)
            state <= IDLE;
          else if (accept && !(RESYNC_ON_LAST && s_axis_last))
            state <= CHECK;
        end
        CHECK: begin
          if (!enable)
            state <= IDLE;
          else if (accept && RESYNC_ON_LAST && s_axis_last)
            state <= SEEK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_incr_pattern_checker.sv
// Testbench for axis_incr_pattern_checker: directed steps, scoreboard of
// expected counter values per accepted beat, immediate assertions.

module tb_axis_incr_pattern_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable, clear;
  logic [1:0]  cfg_ready_mode;
  logic [7:0]  cfg_high_time, cfg_low_time;
  logic        s_valid, s_last;
  logic [63:0] s_data;

  logic        ready, error, locked;
  logic [31:0] beat_count, packet_count, first_err_beat;
  logic [15:0] error_count;

  logic        nr_ready, nr_error, nr_locked;
  logic [31:0] nr_beat_count, nr_packet_count, nr_first_err_beat;
  logic [15:0] nr_error_count;

  axis_incr_pattern_checker #(.DATA_WIDTH(64), .RESYNC_ON_LAST(1'b1)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .cfg_ready_mode(cfg_ready_mode), .cfg_high_time(cfg_high_time),
    .cfg_low_time(cfg_low_time), .s_axis_valid(s_valid), .s_axis_ready(ready),
    .s_axis_data(s_data), .s_axis_last(s_last), .beat_count(beat_count),
    .packet_count(packet_count), .error_count(error_count),
    .first_err_beat(first_err_beat), .error(error), .locked(locked)
  );

  axis_incr_pattern_checker #(.DATA_WIDTH(64), .RESYNC_ON_LAST(1'b0)) dut_nr (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .cfg_ready_mode(cfg_ready_mode), .cfg_high_time(cfg_high_time),
    .cfg_low_time(cfg_low_time), .s_axis_valid(s_valid), .s_axis_ready(nr_ready),
    .s_axis_data(s_data), .s_axis_last(s_last), .beat_count(nr_beat_count),
    .packet_count(nr_packet_count), .error_count(nr_error_count),
    .first_err_beat(nr_first_err_beat), .error(nr_error), .locked(nr_locked)
  );

  typedef struct {
    logic [31:0] beats;
    logic [31:0] pkts;
    logic [15:0] errs;
    logic [31:0] first;
    logic        err;
    logic        lock;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_beats, m_pkts, m_first;
  logic [15:0] m_errs;
  logic        m_err;

  logic [63:0] d;
  logic [7:0]  nb;
  logic [31:0] base;
  logic        got;
  logic [4:0]  pat_bits;

  function automatic logic [63:0] pat(input logic [7:0] b);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = b + 8'(k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_zero();
    m_beats = 0; m_pkts = 0; m_errs = 0; m_first = 0; m_err = 1'b0;
  endtask

  // Update the reference counters for one accepted beat and queue the result.
  task automatic model_push(input logic l, input bit bad, input bit clr, input bit dis);
    exp_t e;
    if (clr) begin
      model_zero();
    end else begin
      if (bad) begin
        if (!m_err) begin
          m_err   = 1'b1;
          m_first = m_beats;
        end
        if (m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
      end
      if (m_beats != 32'hFFFF_FFFF) m_beats = m_beats + 32'd1;
      if (l && m_pkts != 32'hFFFF_FFFF) m_pkts = m_pkts + 32'd1;
    end
    e.beats = m_beats; e.pkts = m_pkts; e.errs = m_errs;
    e.first = m_first; e.err = m_err;
    e.lock  = !(clr || dis || l);
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("beat_count", beat_count, e.beats);
      chk("packet_count", packet_count, e.pkts);
      chk("error_count", 32'(error_count), 32'(e.errs));
      chk("first_err_beat", first_err_beat, e.first);
      chk("error", 32'(error), 32'(e.err));
      chk("locked", 32'(locked), 32'(e.lock));
      $display("beat done: beats=%0d pkts=%0d errs=%0d first=%0d err=%0b lock=%0b",
               beat_count, packet_count, error_count, first_err_beat, error, locked);
    end
  endtask

  // Present one beat (called at a negedge), wait for ready, optionally pair it
  // with clear or with enable falling, then compare after acceptance.
  task automatic send(input logic [63:0] dat, input logic l, input bit bad,
                      input bit clr, input bit dis);
    int w = 0;
    s_valid = 1'b1; s_data = dat; s_last = l;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    assert (ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout: observed %0b expected 1", ready);
    end
    if (clr) clear = 1'b1;
    if (dis) enable = 1'b0;
    model_push(l, bad, clr, dis);
    @(negedge clk);
    clear = 1'b0;
    pop_cmp();
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_clear();
    idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0; clear = 1'b0;
    cfg_ready_mode = 2'd0; cfg_high_time = 8'd0; cfg_low_time = 8'd0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    model_zero();
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_beat", beat_count, 32'd0);
    chk("rst_pkt", packet_count, 32'd0);
    chk("rst_errcnt", 32'(error_count), 32'd0);
    chk("rst_first", first_err_beat, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);

    resetn = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);

    // T1: always ready, 64 incrementing beats, last every 16
    for (int i = 0; i < 64; i++) send(pat(8'(i * 8)), (i % 16) == 15, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t1_beats", beat_count, 32'd64);
    chk("t1_pkts", packet_count, 32'd4);
    chk("t1_errs", 32'(error_count), 32'd0);

    // T2: high=3 low=2 pattern with valid held
    cfg_ready_mode = 2'd1; cfg_high_time = 8'd3; cfg_low_time = 8'd2;
    @(negedge clk);
    pat_bits = 5'b00111;
    base = m_beats;
    nb = 8'h00;
    for (int c = 0; c < 30; c++) begin
      chk("t2_ready_pat", 32'(ready), 32'(pat_bits[c % 5]));
      s_valid = 1'b1; s_data = pat(nb); s_last = 1'b0;
      got = ready;
      if (got) begin
        model_push(1'b0, 1'b0, 1'b0, 1'b0);
        nb = nb + 8'd8;
      end
      @(negedge clk);
      if (got) pop_cmp();
    end
    idle();
    chk("t2_beats", beat_count, base + 32'd18);
    cfg_ready_mode = 2'd0; cfg_high_time = 8'd0; cfg_low_time = 8'd0;
    @(negedge clk);

    // T3: beat 10 of 32 has byte 2 flipped
    pulse_clear();
    chk("t3_clr_beats", beat_count, 32'd0);
    chk("t3_clr_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 32; i++) begin
      d = pat(8'(i * 8));
      if (i == 10) d[23:16] = d[23:16] ^ 8'h01;
      send(d, i == 31, i == 10, 1'b0, 1'b0);
    end
    idle();
    chk("t3_errs", 32'(error_count), 32'd1);
    chk("t3_first", first_err_beat, 32'd10);
    chk("t3_error", 32'(error), 32'd1);

    // T4: seed 0xF8, bytes wrap through 0xFF
    for (int i = 0; i < 4; i++) send(pat(8'hF8 + 8'(i * 8)), i == 3, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t4_errs", 32'(error_count), 32'd1);

    // T5: 8-beat transfer replayed 3x from 0x40
    pulse_clear();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) send(pat(8'h40 + 8'(i * 8)), i == 7, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t5_errs", 32'(error_count), 32'd0);
    chk("t5_pkts", packet_count, 32'd3);
    chk("t5_nr_errs", 32'(nr_error_count), 32'd2);
    chk("t5_nr_pkts", nr_packet_count, 32'd3);
    chk("t5_nr_beats", nr_beat_count, 32'd24);
    chk("t5_nr_first", nr_first_err_beat, 32'd8);

    // Enable falls on an accepted beat: beat processed, ready low afterwards
    send(pat(8'h00), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dis_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("dis_hold_beats", beat_count, 32'd25);
    chk("dis_hold_ready", 32'(ready), 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // T6: clear together with beat 5, then reset mid-packet
    for (int i = 0; i < 5; i++) send(pat(8'h10 + 8'(i * 8)), 1'b0, 1'b0, 1'b0, 1'b0);
    send(pat(8'h38), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_clr_beats", beat_count, 32'd0);
    for (int i = 0; i < 3; i++) send(pat(8'h60 + 8'(i * 8)), 1'b0, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = pat(8'h78); s_last = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ready), 32'd0);
    chk("t6_rst_beats", beat_count, 32'd0);
    chk("t6_rst_pkts", packet_count, 32'd0);
    chk("t6_rst_locked", 32'(locked), 32'd0);
    chk("t6_rst_nr_beats", nr_beat_count, 32'd0);
    chk("t6_rst_nr_errs", 32'(nr_error_count), 32'd0);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
